// File: rtl/mult_seq_ctrl_pkg.sv
// Shared vector execution definitions: controller states, SEW encodings and
// the partial-product lane-to-shift tables used by the accumulator.
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS0 = 2'b01,
    PASS1 = 2'b10,
    DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SEW_8   = 2'b00,
    SEW_16  = 2'b01,
    SEW_32  = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  // Byte shift for each lane k. In 16-bit mode k = 4h+2i+j gives 8(i+j) within
  // a 32-bit field. In 32-bit mode k = 4j'+i gives 8(i+j'), with 16*count_0 added.
  localparam logic [7:0][5:0] SHIFT_16 = {6'd16, 6'd8, 6'd8, 6'd0,
                                          6'd16, 6'd8, 6'd8, 6'd0};
  localparam logic [7:0][5:0] SHIFT_32 = {6'd32, 6'd24, 6'd16, 6'd8,
                                          6'd24, 6'd16, 6'd8,  6'd0};

endpackage

// File: rtl/mult_seq_ctrl_pp_accum.sv
// Combinational shift-and-accumulate network: folds one set of eight 16-bit
// partial products into the 64-bit accumulator according to the element width.
module pp_accum
  import mult_seq_ctrl_pkg::*;
(
  input  logic [127:0] pp_in,
  input  sew_e         sew,
  input  logic         count_0,
  input  logic [63:0]  acc,
  output logic [63:0]  acc_next
);

  logic [31:0] field;
  logic [63:0] sum;
  logic [5:0]  pass_shift;

  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_next   = acc;
    field      = '0;
    sum        = '0;
    pass_shift = count_0 ? 6'd16 : 6'd0;
    case (sew)
      SEW_8: begin
        for (int k = 0; k < 4; k++)
          acc_next[16*k +: 16] = acc[16*k +: 16] + pp_in[16*k +: 16];
      end
      SEW_16: begin
        for (int h = 0; h < 2; h++) begin
          field = acc[32*h +: 32];
          for (int n = 0; n < 4; n++)
            field = field + (32'(pp_in[16*(4*h+n) +: 16]) << SHIFT_16[4*h+n]);
          acc_next[32*h +: 32] = field;
        end
      end
      SEW_32: begin
        sum = acc;
        for (int k = 0; k < 8; k++)
          sum = sum + (64'(pp_in[16*k +: 16]) << (SHIFT_32[k] + pass_shift));
        acc_next = sum;
      end
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for an external 8-lane byte multiplier array: latches
// operands, steps one or two accumulate passes and holds the result until taken.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   data_in_A,
  input  logic [31:0]   data_in_B,
  input  logic [1:0]    sew_in,
  output logic [31:0]   mul_A,
  output logic [31:0]   mul_B,
  output logic [1:0]    mul_sew,
  output logic          mul_count_0,
  input  logic [127:0]  pp_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   result,
  output logic          err
);

  state_e      state_q, state_d;
  sew_e        sew_q;
  logic [63:0] acc_q, acc_next;
  logic        err_q;
  logic        accept;

  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (sew_e'(sew_in) == SEW_ILL) ? DONE : PASS0;
      PASS0:   state_d = (sew_q == SEW_32) ? PASS1 : DONE;
      PASS1:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_A       <= '0;
      mul_B       <= '0;
      sew_q       <= SEW_8;
      mul_count_0 <= 1'b0;
      acc_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mul_A       <= data_in_A;
          mul_B       <= data_in_B;
          sew_q       <= sew_e'(sew_in);
          mul_count_0 <= 1'b0;
          acc_q       <= '0;
          err_q       <= (sew_e'(sew_in) == SEW_ILL);
        end
        PASS0: begin
          acc_q <= acc_next;
          if (sew_q == SEW_32) mul_count_0 <= 1'b1;
        end
        PASS1: begin
          acc_q       <= acc_next;
          mul_count_0 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  pp_accum u_pp_accum (
    .pp_in    (pp_in),
    .sew      (sew_q),
    .count_0  (mul_count_0),
    .acc      (acc_q),
    .acc_next (acc_next)
  );

  // Ready is gated by reset so it reads low for the whole reset assertion.
  assign in_ready  = reset && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;
  assign err       = err_q && (state_q == DONE);
  assign mul_sew   = sew_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural byte-multiplier array
// feeding pp_in from the latched operands.
module tb_mult_seq_ctrl;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   data_in_A, data_in_B;
  logic [1:0]    sew_in;
  logic [31:0]   mul_A, mul_B;
  logic [1:0]    mul_sew;
  logic          mul_count_0;
  logic [127:0]  pp_in;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   result;
  logic          err;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_trace;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in_A   (data_in_A),
    .data_in_B   (data_in_B),
    .sew_in      (sew_in),
    .mul_A       (mul_A),
    .mul_B       (mul_B),
    .mul_sew     (mul_sew),
    .mul_count_0 (mul_count_0),
    .pp_in       (pp_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .err         (err)
  );

  // External array model; unused lanes carry junk so ignoring them is exercised.
  always_comb begin
    pp_in = {8{16'h5A5A}};
    case (mul_sew)
      2'b00: begin
        for (int k = 0; k < 4; k++)
          pp_in[16*k +: 16] = 16'(mul_A[8*k +: 8]) * 16'(mul_B[8*k +: 8]);
        for (int k = 4; k < 8; k++) pp_in[16*k +: 16] = 16'hA5A5;
      end
      2'b01: begin
        for (int h = 0; h < 2; h++)
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              pp_in[16*(4*h+2*i+j) +: 16] =
                16'(mul_A[8*(2*h+i) +: 8]) * 16'(mul_B[8*(2*h+j) +: 8]);
      end
      2'b10: begin
        for (int jp = 0; jp < 2; jp++)
          for (int i = 0; i < 4; i++)
            pp_in[16*(4*jp+i) +: 16] =
              16'(mul_A[8*i +: 8]) * 16'(mul_B[8*(2*int'(mul_count_0)+jp) +: 8]);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res,
                       input logic exp_err, input int exp_lat, input int hold,
                       input bit busy_noise);
    int cyc;
    bit seen;
    logic [63:0] held;
    @(negedge clk);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; data_in_A = a; data_in_B = b; sew_in = s;
    cyc = 0; seen = 1'b0; last_trace = '0;
    while (!seen && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      last_trace[cyc] = mul_count_0;
      if (busy_noise) begin
        data_in_A = ~a; data_in_B = 32'h1234_5678; sew_in = 2'b11;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_mul_A"}, 64'(mul_A), 64'(a));
    held = result;
    for (int n = 0; n < hold; n++) begin
      @(posedge clk); #1;
      check({tag, "_hold_result"}, result, held);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_release_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_release_err"}, 64'(err), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_mul_A"}, 64'(mul_A), 64'd0);
    check({tag, "_mul_B"}, 64'(mul_B), 64'd0);
    check({tag, "_mul_sew"}, 64'(mul_sew), 64'd0);
    check({tag, "_mul_count_0"}, 64'(mul_count_0), 64'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in_A = '0; data_in_B = '0; sew_in = 2'b00;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("por_release_ready", 64'(in_ready), 64'd1);

    do_op("s8_vec",  2'b00, 32'h0203_0405, 32'h0607_0809, 64'h000C_0015_0020_002D, 1'b0, 2, 0, 1'b0);
    do_op("s16_vec", 2'b01, 32'h0002_0003, 32'h0004_0005, 64'h0000_0008_0000_000F, 1'b0, 2, 0, 1'b0);
    do_op("s32_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 3, 0, 1'b0);
    check("s32_max_count_pass0", 64'(last_trace[1]), 64'd0);
    check("s32_max_count_pass1", 64'(last_trace[2]), 64'd1);
    check("s32_max_count_done",  64'(last_trace[3]), 64'd0);
    do_op("s_ill",   2'b11, 32'h1111_1111, 32'h2222_2222, 64'd0, 1'b1, 1, 0, 1'b0);
    do_op("s8_hold", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFE01_FE01_FE01_FE01, 1'b0, 2, 5, 1'b0);
    do_op("s16_busy", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFE_0001_FFFE_0001, 1'b0, 2, 0, 1'b1);
    do_op("s32_shift", 2'b10, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 1'b0, 3, 0, 1'b0);
    do_op("s32_b2b",   2'b10, 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, 1'b0, 3, 0, 1'b0);

    // Result taken and new request offered in the same DONE cycle.
    @(negedge clk);
    in_valid = 1'b1; data_in_A = 32'h0101_0101; data_in_B = 32'h0101_0101; sew_in = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ovl_first_result", result, 64'h0001_0001_0001_0001);
    out_ready = 1'b1; in_valid = 1'b1;
    data_in_A = 32'h0101_0101; data_in_B = 32'h0202_0202;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ovl_not_accepted_valid", 64'(out_valid), 64'd0);
    check("ovl_not_accepted_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ovl_accepted_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("ovl_second_valid", 64'(out_valid), 64'd1);
    check("ovl_second_result", result, 64'h0002_0002_0002_0002);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in PASS1 of a 32-bit operation.
    @(negedge clk);
    in_valid = 1'b1; data_in_A = 32'hFFFF_FFFF; data_in_B = 32'hFFFF_FFFF; sew_in = 2'b10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pass1_count", 64'(mul_count_0), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_abort");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_abort_release_ready", 64'(in_ready), 64'd1);
    do_op("s8_after_rst", 2'b00, 32'h0203_0405, 32'h0607_0809, 64'h000C_0015_0020_002D, 1'b0, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
